// File: rtl/filt3_tx_if.sv
// Request/response bundle for filt3_tx: pulse request handshake plus the line and status outputs.
interface filt3_tx_if #(
    parameter int LEN_W = 8
);
    logic             req_valid;
    logic [LEN_W-1:0] req_len;
    logic             req_ready;
    logic             y;
    logic             busy;
    logic             done;

    modport master (
        output req_valid,
        output req_len,
        input  req_ready,
        input  y,
        input  busy,
        input  done
    );

    modport slave (
        input  req_valid,
        input  req_len,
        output req_ready,
        output y,
        output busy,
        output done
    );
endinterface

// File: rtl/filt3_tx.sv
// Pulse generator whose output survives a downstream consecutive-sample glitch filter:
// every pulse is at least MIN_HIGH cycles high and followed by at least MIN_LOW cycles low.
module filt3_tx #(
    parameter int LEN_W    = 8,
    parameter int MIN_HIGH = 3,
    parameter int MIN_LOW  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    filt3_tx_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_HIGH = 2'b01;
    localparam logic [1:0] ST_GAP  = 2'b10;

    localparam logic [LEN_W-1:0] MIN_HIGH_V = LEN_W'(MIN_HIGH);
    localparam logic [LEN_W-1:0] LOW_RELOAD = LEN_W'(MIN_LOW - 1);
    localparam logic [LEN_W-1:0] ONE        = LEN_W'(1);
    localparam logic [LEN_W-1:0] ZERO       = '0;

    // Short requests (including 0) are raised to the minimum the receiver filter can pass.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len < MIN_HIGH_V) ? MIN_HIGH_V : len;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] cnt_q,   cnt_d;
    logic             y_q,     y_d;
    logic             done_q,  done_d;
    logic             ready;
    logic             accept;

    assign ready  = (state_q == ST_IDLE) && rst_n;
    assign accept = bus.req_valid && ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                y_d = 1'b0;
                if (accept) begin
                    cnt_d   = clamp_len(bus.req_len) - ONE;
                    y_d     = 1'b1;
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                y_d = 1'b1;
                if (cnt_q != ZERO) begin
                    cnt_d = cnt_q - ONE;
                end else begin
                    y_d     = 1'b0;
                    cnt_d   = LOW_RELOAD;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                y_d = 1'b0;
                if (cnt_q != ZERO) begin
                    cnt_d = cnt_q - ONE;
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = ZERO;
                y_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= ZERO;
            y_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            done_q  <= done_d;
        end
    end

    assign bus.req_ready = ready;
    assign bus.y         = y_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = done_q;
endmodule

// File: tb/tb_filt3_tx.sv
// Directed bench for filt3_tx: table of single pulses, back-to-back stream, mid-pulse reset,
// and a loopback through a 3-sample filter model with random request lengths.
module tb_filt3_tx;
    localparam int LEN_W    = 8;
    localparam int MIN_HIGH = 3;
    localparam int MIN_LOW  = 3;

    logic clk;
    logic rst_n;

    filt3_tx_if #(.LEN_W(LEN_W)) bus ();

    filt3_tx #(
        .LEN_W   (LEN_W),
        .MIN_HIGH(MIN_HIGH),
        .MIN_LOW (MIN_LOW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [LEN_W-1:0] len;
        int               eff;
    } vec_t;
    vec_t vecs [8];

    // Filter model state, advanced once per sample.
    logic yd1 = 1'b0, yd2 = 1'b0, yd3 = 1'b0;
    logic f_state = 1'b0, f_prev = 1'b0;
    bit   lb_en = 1'b0;
    int   y_rise = 0, f_rise = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: move to the next falling edge, then sample and run the filter model.
    task automatic tick();
        logic ys, f_out;
        @(negedge clk);
        ys    = bus.y;
        f_out = f_state;
        if (lb_en) begin
            chk("loopback_delay3", int'(f_out), int'(yd3));
            if (ys && !yd1) y_rise++;
            if (f_out && !f_prev) f_rise++;
        end
        f_prev = f_out;
        if (ys && yd1 && yd2) f_state = 1'b1;
        else if (!ys && !yd1 && !yd2) f_state = 1'b0;
        yd3 = yd2;
        yd2 = yd1;
        yd1 = ys;
    endtask

    function automatic int pack4();
        return int'({bus.y, bus.busy, bus.req_ready, bus.done});
    endfunction

    // Issue one request from IDLE and verify the full high/gap/done waveform.
    task automatic run_pulse(input logic [LEN_W-1:0] len, input int eff, input string name);
        int exp;
        tick();
        chk({name, "_ready"}, int'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.req_len   = len;
        for (int i = 1; i <= eff + MIN_LOW + 1; i++) begin
            tick();
            if (i == 1) bus.req_valid = 1'b0;
            if (i <= eff)               exp = 4'b1100;
            else if (i <= eff + MIN_LOW) exp = 4'b0100;
            else                         exp = 4'b0011;
            chk($sformatf("%s_cyc%0d", name, i), pack4(), exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int budget = 64;
        while (!bus.req_ready && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) chk({name, "_ready_timeout"}, 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int exp;

        vecs[0] = '{len: 8'd5,   eff: 5};
        vecs[1] = '{len: 8'd0,   eff: 3};
        vecs[2] = '{len: 8'd1,   eff: 3};
        vecs[3] = '{len: 8'd2,   eff: 3};
        vecs[4] = '{len: 8'd3,   eff: 3};
        vecs[5] = '{len: 8'd4,   eff: 4};
        vecs[6] = '{len: 8'd9,   eff: 9};
        vecs[7] = '{len: 8'd255, eff: 255};

        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_len   = '0;
        repeat (3) tick();
        chk("reset_outputs", pack4(), 4'b0000);

        rst_n = 1'b1;
        tick();
        chk("post_reset_idle", pack4(), 4'b0010);

        for (int v = 0; v < 8; v++)
            run_pulse(vecs[v].len, vecs[v].eff, $sformatf("pulse_len%0d", vecs[v].len));

        // Continuous valid: one accept every eff+MIN_LOW+1 = 8 cycles.
        tick();
        bus.req_valid = 1'b1;
        bus.req_len   = 8'd4;
        acc = (bus.req_ready) ? 1 : 0;
        for (int i = 1; i <= 39; i++) begin
            tick();
            exp = ((i - 1) % 8 < 4) ? 1 : 0;
            chk($sformatf("stream_y%0d", i), int'(bus.y), exp);
            exp = ((i - 1) % 8 == 7) ? 1 : 0;
            chk($sformatf("stream_done%0d", i), int'(bus.done), exp);
            chk($sformatf("stream_ready%0d", i), int'(bus.req_ready), exp);
            if (bus.req_ready && bus.req_valid) acc++;
        end
        bus.req_valid = 1'b0;
        chk("stream_accepts", acc, 5);
        tick();
        chk("stream_last_done", pack4(), 4'b0011);

        // Reset while HIGH with 10 cycles left.
        tick();
        bus.req_valid = 1'b1;
        bus.req_len   = 8'd20;
        tick();
        bus.req_valid = 1'b0;
        repeat (9) tick();
        chk("midreset_was_high", int'(bus.y), 1);
        rst_n = 1'b0;
        tick();
        chk("midreset_aborted", pack4(), 4'b0000);
        rst_n = 1'b1;
        tick();
        chk("midreset_idle_nodone", pack4(), 4'b0010);
        run_pulse(8'd6, 6, "after_reset");

        // Loopback through the 3-sample filter model.
        repeat (4) tick();
        lb_en  = 1'b1;
        y_rise = 0;
        f_rise = 0;
        for (int r = 0; r < 100; r++) begin
            wait_ready("loopback");
            bus.req_valid = 1'b1;
            bus.req_len   = LEN_W'($urandom_range(0, 20));
            tick();
            bus.req_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (40) tick();
        chk("loopback_edges", f_rise, y_rise);
        chk("loopback_pulse_count", y_rise, 100);
        lb_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
